// File: rtl/riscv_dmem_responder.sv
// -----------------------------------------------------------------------------
// riscv_dmem_responder
//
// Memory end of the riscv32i load/store port. It holds the word-organised data
// RAM and serves one load or store at a time:
//   - accepts a request over a valid/ready handshake,
//   - spends one decode cycle plus WAIT_STATES extra cycles,
//   - commits a store or reads a load on the edge entering the response state,
//   - holds the response until the consumer takes it.
// Applies RV32I byte/halfword/word lane selection and load sign/zero extension.
//
// Optional build macro:
//   DMEM_MISALIGN_CHECK_EN  - misaligned halfword/word accesses return an error.
//                             When undefined, such accesses are forced aligned.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   req_valid     request present            req_ready   block can accept
//   req_we        1 = store, 0 = load        req_addr    byte address
//   req_funct3    RV32I width code           req_wdata   right-aligned store data
//   rsp_valid     response present           rsp_ready   consumer takes response
//   rsp_rdata     extended load data (0 for stores and errors)
//   rsp_err       out-of-range, illegal funct3 or (optionally) misaligned
// -----------------------------------------------------------------------------
module riscv_dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1,
    parameter int ADDR_BASE   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    // Control and output flops
    state_t            state_q,     state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [CNT_W-1:0]  wait_cnt_q,  wait_cnt_d;
    // Latched request
    logic              we_q,        we_d;
    logic [XLEN-1:0]   addr_q,      addr_d;
    logic [2:0]        funct3_q,    funct3_d;
    logic [XLEN-1:0]   wdata_q,     wdata_d;

    logic [XLEN-1:0]   mem [DEPTH_WORDS];

    // Decode of the latched request
    logic [XLEN-1:0]   offset;
    logic [XLEN-1:0]   word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              out_of_range;
    logic              bad_funct3;
    logic              misaligned;
    logic              acc_err;
    size_t             size;
    logic [1:0]        lane;
    logic [3:0]        byte_en;
    logic [XLEN-1:0]   wr_data;
    logic [XLEN-1:0]   rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [XLEN-1:0]   load_data;
    logic              wait_done;
    logic              commit;

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        offset       = addr_q - XLEN'(ADDR_BASE);
        word_idx     = offset >> 2;
        out_of_range = (addr_q < XLEN'(ADDR_BASE)) || (word_idx >= XLEN'(DEPTH_WORDS));
        // Keep the RAM index in bounds even when the request is rejected.
        mem_idx      = out_of_range ? '0 : word_idx[IDX_W-1:0];

        size       = SZ_W;
        bad_funct3 = 1'b0;
        case (funct3_q)
            3'b000:  size = SZ_B;
            3'b001:  size = SZ_H;
            3'b010:  size = SZ_W;
            3'b100:  begin size = SZ_B; bad_funct3 = we_q; end  // LBU, no store form
            3'b101:  begin size = SZ_H; bad_funct3 = we_q; end  // LHU, no store form
            default: bad_funct3 = 1'b1;
        endcase

        // Lane of the lowest accessed byte; sub-lane address bits are dropped
        // for halfword/word accesses.
        case (size)
            SZ_B:    lane = addr_q[1:0];
            SZ_H:    lane = {addr_q[1], 1'b0};
            default: lane = 2'b00;
        endcase

`ifdef DMEM_MISALIGN_CHECK_EN
        misaligned = ((size == SZ_H) && addr_q[0]) ||
                     ((size == SZ_W) && (addr_q[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif

        acc_err = out_of_range || bad_funct3 || misaligned;

        case (size)
            SZ_B:    begin byte_en = 4'b0001 << lane; wr_data = {4{wdata_q[7:0]}};  end
            SZ_H:    begin byte_en = 4'b0011 << lane; wr_data = {2{wdata_q[15:0]}}; end
            default: begin byte_en = 4'b1111;         wr_data = wdata_q;            end
        endcase

        rd_word = mem[mem_idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = rd_word[{lane[1], 4'b0000} +: 16];
        // funct3[2] selects zero extension (LBU/LHU).
        case (size)
            SZ_B:    load_data = {{(XLEN-8){rd_byte[7] & ~funct3_q[2]}}, rd_byte};
            SZ_H:    load_data = {{(XLEN-16){rd_half[15] & ~funct3_q[2]}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    // WAIT lasts one decode cycle plus WAIT_STATES cycles.
    assign wait_done = (state_q == S_WAIT) && (wait_cnt_q == CNT_W'(WAIT_STATES));
    // Writes happen only on the edge entering RESP, never while reset is held.
    assign commit    = wait_done && we_q && !acc_err && !rst;

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wait_cnt_d  = wait_cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        wdata_d     = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    funct3_d    = req_funct3;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    wait_cnt_d  = '0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_done) begin
                    wait_cnt_d  = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_err;
                    rsp_rdata_d = (we_q || acc_err) ? '0 : load_data;
                    state_d     = S_RESP;
                end else begin
                    wait_cnt_d  = wait_cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                // No accept in this cycle; IDLE re-opens req_ready next cycle.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            funct3_q    <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wait_cnt_q  <= wait_cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            wdata_q     <= wdata_d;
        end
    end

    // NOTE: the RAM has no reset; its contents survive rst and start undefined.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
